// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Multi-cycle 16x16 unsigned shift-add multiplier. It drives the
//               external combinational ALU with ADD operations and performs
//               the shifts internally, returning a 32-bit product through a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_NOP = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [15:0] mcand,
    input  logic [15:0] mplier,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_out,
    input  logic        alu_cf,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] product,
    output logic        busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_add   = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]  r_state;
    logic [15:0] r_m;
    logic [15:0] r_hi;
    logic [15:0] r_lo;
    logic        r_c;
    logic [3:0]  r_cnt;

    logic        w_accept;
    logic        w_zero_op;

    assign w_accept  = start_valid && start_ready;
    assign w_zero_op = (mcand == 16'h0000) || (mplier == 16'h0000);

    // Handshake and status flags decode straight from the state register
    assign start_ready = (r_state == c_st_idle);
    assign res_valid   = (r_state == c_st_done);
    assign busy        = (r_state != c_st_idle);
    assign product     = {r_hi, r_lo};

    // ALU request: only the ADD state issues work; a zero B operand makes the
    // ALU return HI unchanged with no carry when the multiplier bit is clear
    always_comb begin
        alu_op = OP_NOP;
        alu_a  = 16'h0000;
        alu_b  = 16'h0000;
        if (r_state == c_st_add) begin
            alu_op = OP_ADD;
            alu_a  = r_hi;
            alu_b  = r_lo[0] ? r_m : 16'h0000;
        end
    end

    // Sequencer: accept operands, alternate ADD/SHIFT sixteen times, hold result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_m     <= 16'h0000;
            r_hi    <= 16'h0000;
            r_lo    <= 16'h0000;
            r_c     <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_m   <= mcand;
                        r_hi  <= 16'h0000;
                        r_c   <= 1'b0;
                        r_cnt <= 4'd0;
                        if (w_zero_op) begin
                            // Zero operand: product is known, skip the iterations
                            r_lo    <= 16'h0000;
                            r_state <= c_st_done;
                        end else begin
                            r_lo    <= mplier;
                            r_state <= c_st_add;
                        end
                    end
                end
                c_st_add: begin
                    r_hi    <= alu_out;
                    r_c     <= alu_cf;
                    r_state <= c_st_shift;
                end
                c_st_shift: begin
                    // Carry re-enters at the top so no product bit is lost
                    r_hi  <= {r_c, r_hi[15:1]};
                    r_lo  <= {r_hi[0], r_lo[15:1]};
                    r_c   <= 1'b0;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state <= c_st_done;
                    end else begin
                        r_state <= c_st_add;
                    end
                end
                c_st_done: begin
                    if (res_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
